fetch_queue: RTL and testbench

Instruction fetch front-end with prefetch buffering, sitting directly upstream of the fetch/decode pipeline register. It drives a multi-cycle instruction memory over a request/grant/response handshake and keeps up to DEPTH instructions, each with its PC, in a FIFO. It presents one instruction per cycle to the fetch stage. On a taken branch or jump it flushes all buffered and in-flight work and restarts at the redirect target.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_queue.sv | 124 ++++++++++++
 tb/tb_fetch_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; wrap-around pointers carry one extra bit
// so full and empty are distinguishable without a separate counter.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  fetch_entry_t                 i_data,
   input  logic                         i_pop,
   input  logic                         i_clear,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output fetch_entry_t                 o_head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_entry_t r_mem [DEPTH];
   logic [AW:0]  r_wr;
   logic [AW:0]  r_rd;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else if (i_clear) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + (AW+1)'(1);
         if (i_pop)  r_rd <= r_rd + (AW+1)'(1);
      end
   end

   // Storage needs no reset: contents are only observed through valid pointers.
   always_ff @(posedge clk) begin
      if (i_push && !i_clear) r_mem[r_wr[AW-1:0]] <= i_data;
   end

   assign o_count = CW'(r_wr - r_rd);
   assign o_empty = (r_wr == r_rd);
   assign o_full  = (o_count == CW'(DEPTH));
   assign o_head  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: drives a multi-cycle imem handshake, buffers
// fetched instructions with their PCs, and flushes on redirect.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        deq_ready,
   output logic        instr_valid,
   output logic [31:0] instr_f,
   output logic [31:0] pc_f,
   output logic [31:0] pc_plus4_f
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = $clog2(DEPTH);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [31:0]  r_fetch_pc;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_drop;
   logic [CW-1:0] w_inflight_nxt;
   logic [CW-1:0] w_drop_nxt;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_grant;
   logic          w_rsp;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   r_pc_mem [DEPTH];
   logic [AW-1:0] r_pc_wr;
   logic [AW-1:0] r_pc_rd;
   logic [31:0]   w_rsp_pc;
   fetch_entry_t  w_push_entry;
   fetch_entry_t  w_head;

   // Every in-flight request holds a reserved slot, so a response never finds the queue full.
   assign imem_req  = rst && (r_state == RUN) && !redirect && !w_full &&
                      (((CW+1)'(w_count) + (CW+1)'(r_inflight)) < (CW+1)'(DEPTH));
   assign imem_addr = r_fetch_pc;

   // A response with nothing outstanding belongs to pre-reset traffic and is ignored.
   assign w_grant = imem_req && imem_gnt;
   assign w_rsp   = imem_rvalid && (r_inflight != '0);
   assign w_push  = w_rsp && (r_drop == '0) && !redirect;
   assign w_pop   = !w_empty && deq_ready && !redirect;

   assign w_inflight_nxt = r_inflight + CW'(w_grant) - CW'(w_rsp);

   always_ff @(posedge clk) begin
      if (!rst) r_state <= RUN;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_drop_nxt  = r_drop;
      if (redirect) begin
         w_drop_nxt  = w_inflight_nxt;
         w_state_nxt = (w_inflight_nxt != '0) ? DRAIN : RUN;
      end else begin
         if (w_rsp && (r_drop != '0)) w_drop_nxt = r_drop - CW'(1);
         if ((r_state == DRAIN) && (w_drop_nxt == '0)) w_state_nxt = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
         r_pc_wr    <= '0;
         r_pc_rd    <= '0;
      end else begin
         r_inflight <= w_inflight_nxt;
         r_drop     <= w_drop_nxt;
         if (redirect)     r_fetch_pc <= redirect_pc;
         else if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
         if (w_grant) r_pc_wr <= r_pc_wr + AW'(1);
         if (w_rsp)   r_pc_rd <= r_pc_rd + AW'(1);
      end
   end

   // In-order PC record: written at grant, consumed by every tracked response, stale or not.
   always_ff @(posedge clk) begin
      if (w_grant) r_pc_mem[r_pc_wr] <= r_fetch_pc;
   end

   assign w_rsp_pc     = r_pc_mem[r_pc_rd];
   assign w_push_entry = '{instr: imem_rdata, pc: w_rsp_pc};

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .i_clear (redirect),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign instr_valid = !w_empty;
   assign instr_f     = w_empty ? NOP_INSTR : w_head.instr;
   assign pc_f        = w_empty ? 32'd0 : w_head.pc;
   assign pc_plus4_f  = w_empty ? 32'd0 : (w_head.pc + 32'd4);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue with an epoch-tagged memory model.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        deq_ready = 1'b0;
   logic        instr_valid;
   logic [31:0] instr_f;
   logic [31:0] pc_f;
   logic [31:0] pc_plus4_f;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
      .instr_valid(instr_valid), .instr_f(instr_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f)
   );

   typedef struct {
      logic [31:0] addr;
      int unsigned tag;
      int unsigned due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   req_t        pend[$];
   ent_t        hold_q[$];
   int unsigned epoch = 0;
   int unsigned cyc = 0;
   logic [31:0] exp_fetch = RESET_PC;
   int          checks = 0;
   int          errors = 0;
   int          pops = 0;
   int unsigned lat_min = 1, lat_max = 1;
   int unsigned gnt_pct = 100, deq_pct = 100, redir_pct = 0;
   logic        rst_drv = 1'b0;
   logic        force_redir = 1'b0;
   logic [31:0] force_pc = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs after the falling edge, then commit the model for the next rising edge.
   task automatic step();
      req_t        r;
      ent_t        e;
      logic        have_push;
      logic        exp_req;
      int unsigned stale;
      @(negedge clk);
      #1;
      rst         = rst_drv;
      redirect    = force_redir || (rst_drv && ($urandom_range(99) < redir_pct));
      redirect_pc = force_redir ? force_pc : ($urandom & 32'hFFFF_FFFC);
      imem_gnt    = ($urandom_range(99) < gnt_pct);
      deq_ready   = ($urandom_range(99) < deq_pct);
      if (rst_drv && pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #1;
      stale = 0;
      foreach (pend[i]) if (pend[i].tag != epoch) stale++;
      exp_req = rst && !redirect && (stale == 0) && ((hold_q.size() + pend.size()) < DEPTH);
      check("imem_req", imem_req, exp_req);
      if (!rst) begin
         hold_q.delete();
         pend.delete();
         epoch++;
         exp_fetch = RESET_PC;
      end else begin
         have_push = 1'b0;
         if (imem_rvalid) begin
            r = pend.pop_front();
            if (r.tag == epoch && !redirect) begin
               e.pc      = r.addr;
               e.instr   = mem_word(r.addr);
               have_push = 1'b1;
            end
         end
         if (deq_ready && hold_q.size() > 0 && !redirect) begin
            e = hold_q.pop_front();
            pops++;
            if (have_push) begin
               e.pc    = r.addr;
               e.instr = mem_word(r.addr);
            end
         end
         if (have_push) hold_q.push_back(e);
         if (imem_req && imem_gnt) begin
            check("imem_addr", imem_addr, exp_fetch);
            r.addr = imem_addr;
            r.tag  = epoch;
            r.due  = cyc + $urandom_range(lat_max, lat_min);
            pend.push_back(r);
            exp_fetch = exp_fetch + 32'd4;
         end
         if (redirect) begin
            hold_q.delete();
            epoch++;
            exp_fetch = redirect_pc;
         end
      end
      cyc++;
   endtask

   // Monitor: the head must always show the oldest entry the model says is buffered.
   initial begin
      forever begin
         @(negedge clk);
         if (hold_q.size() > 0) begin
            check("instr_valid", instr_valid, 1);
            check("pc_f", pc_f, hold_q[0].pc);
            check("instr_f", instr_f, hold_q[0].instr);
            check("pc_plus4_f", pc_plus4_f, hold_q[0].pc + 32'd4);
         end else begin
            check("instr_valid_empty", instr_valid, 0);
            check("instr_f_empty", instr_f, NOP_INSTR);
            check("pc_f_empty", pc_f, 32'd0);
            check("pc_plus4_f_empty", pc_plus4_f, 32'd0);
         end
      end
   end

   initial begin
      int p0;
      rst_drv = 1'b0;
      repeat (3) step();

      // Streaming with single-cycle memory must approach one instruction per cycle.
      rst_drv = 1'b1;
      p0 = pops;
      repeat (60) step();
      check("throughput", 32'((pops - p0) >= 50), 1);

      // Back-pressure fills the queue, then release.
      deq_pct = 0;
      repeat (20) step();
      deq_pct = 100;
      repeat (20) step();

      // Redirect with requests in flight, then a second redirect while draining.
      lat_min = 3; lat_max = 3;
      repeat (10) step();
      force_redir = 1'b1;
      force_pc = 32'h0000_0100;
      step();
      force_pc = 32'h0000_0200;
      step();
      force_redir = 1'b0;
      repeat (30) step();

      // Randomized traffic with redirects, back-pressure, and variable latency.
      lat_min = 1; lat_max = 5;
      gnt_pct = 70; deq_pct = 70; redir_pct = 8;
      repeat (1500) step();

      // Reset mid-stream with a full queue.
      lat_min = 1; lat_max = 1;
      gnt_pct = 100; deq_pct = 0; redir_pct = 0;
      repeat (15) step();
      rst_drv = 1'b0;
      repeat (2) step();
      rst_drv = 1'b1;
      deq_pct = 100;
      repeat (30) step();

      check("activity", 32'(pops > 200), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
